// File: rtl/booth_div_if.sv
// rtl/booth_div_if.sv - request/result bundle for the 320/64 restoring divider
interface booth_div_if;
  logic         start;
  logic [319:0] P;
  logic [63:0]  B;
  logic [255:0] Q;
  logic [63:0]  R;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic         overflow;

  modport master (output start, P, B, input Q, R, busy, done, div_zero, overflow);
  modport slave  (input start, P, B, output Q, R, busy, done, div_zero, overflow);
endinterface

// File: rtl/booth_div.sv
// rtl/booth_div.sv - sequential restoring divider, 320-bit dividend by 64-bit divisor
module booth_div (
  input  logic       clk,
  input  logic       rst,
  booth_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t         state, state_nxt;
  logic [63:0]    rem, b_reg, r_out;
  logic [255:0]   qreg, q_out;
  logic [8:0]     cnt;
  logic           div_zero_r, overflow_r;
  logic           busy_c, done_c;

  logic           accept, p_ovf, special, last;
  logic [64:0]    t;
  logic           ge;
  logic [63:0]    rem_nxt;
  logic [255:0]   qreg_nxt;

  assign accept  = bus.start && (state != CALC);
  assign p_ovf   = bus.P[319:256] >= bus.B;
  assign special = (bus.B == 64'd0) || p_ovf;
  assign last    = (state == CALC) && (cnt == 9'd255);

  // One restoring step; when t >= B the difference always fits in 64 bits
  assign t        = {rem, qreg[255]};
  assign ge       = t >= {1'b0, b_reg};
  assign rem_nxt  = ge ? (t[63:0] - b_reg) : t[63:0];
  assign qreg_nxt = {qreg[254:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = special ? FIN : CALC;
      CALC:    if (last) state_nxt = FIN;
      FIN:     if (bus.start) state_nxt = special ? FIN : CALC;
               else state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      CALC:    busy_c = 1'b1;
      FIN:     done_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem        <= '0;
      qreg       <= '0;
      b_reg      <= '0;
      cnt        <= '0;
      q_out      <= '0;
      r_out      <= '0;
      div_zero_r <= 1'b0;
      overflow_r <= 1'b0;
    end else if (accept) begin
      div_zero_r <= 1'b0;
      overflow_r <= 1'b0;
      b_reg      <= bus.B;
      if (bus.B == 64'd0) begin
        q_out      <= '1;
        r_out      <= bus.P[63:0];
        div_zero_r <= 1'b1;
      end else if (p_ovf) begin
        q_out      <= '1;
        r_out      <= '0;
        overflow_r <= 1'b1;
      end else begin
        rem  <= bus.P[319:256];
        qreg <= bus.P[255:0];
        cnt  <= '0;
      end
    end else if (state == CALC) begin
      rem  <= rem_nxt;
      qreg <= qreg_nxt;
      cnt  <= cnt + 9'd1;
      if (cnt == 9'd255) begin
        q_out <= qreg_nxt;
        r_out <= rem_nxt;
      end
    end
  end

  assign bus.Q        = q_out;
  assign bus.R        = r_out;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.div_zero = div_zero_r;
  assign bus.overflow = overflow_r;
endmodule
